ahb_burst_checker: RTL

Parametrised, synthesizable AHB protocol checker. It passively observes the same master/slave signal set the AHB agents drive and sample. It tracks every burst's address sequence, control stability, beat count and wait states, and reports protocol violations as registered error pulses with a code and address. It sits beside the AHB side of the AHB2APB bridge, in RTL or in the bench, and never drives the bus.

---
 rtl/ahb_burst_checker.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_burst_checker.sv
// Passive AHB burst checker: tracks address sequence, control stability, beat count and waits; flags violations.
// Define AHB_CHK_TIMEOUT_EN to build the wait-state counter and the timeout error (code 7).
module ahb_burst_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clock,
    input  logic                  Hreset,
    input  logic [1:0]            Htrans,
    input  logic [2:0]            Hburst,
    input  logic [2:0]            Hsize,
    input  logic                  Hwrite,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic                  Hreadyin,
    input  logic                  Hreadyout,
    input  logic [1:0]            Hresp,
    output logic                  burst_active,
    output logic [4:0]            beat_count,
    output logic                  err_valid,
    output logic [3:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [15:0]           txn_count,
    output logic [7:0]            err_count
);
    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                state_q, state_d;
    logic [2:0]            size_q, size_d, burst_q, burst_d;
    logic                  write_q, write_d, abort_q, abort_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d, prev_addr_q, prev_addr_d;
    logic [4:0]            beat_q, beat_d;
    logic                  err_valid_q, err_valid_d;
    logic [3:0]            err_code_q, err_code_d, code_sel;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [15:0]           txn_q, txn_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  accept, is_seq, is_busy, is_nonseq, is_idle, in_burst;
    logic                  fixed_q, resp_err, open_evt, timeout_hit;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [8:1]            hit;
    logic                  unused_hreadyin;

    assign unused_hreadyin = Hreadyin;
    assign accept    = Hreadyout && Htrans[1];
    assign is_idle   = Htrans == 2'b00;
    assign is_busy   = Htrans == 2'b01;
    assign is_nonseq = Htrans == 2'b10;
    assign is_seq    = Htrans == 2'b11;
    assign in_burst  = state_q == ST_BURST;
    assign fixed_q   = burst_q[2:1] != 2'b00;
    assign resp_err  = Hresp == 2'b01;
    assign size_mask = (ADDR_WIDTH'(1) << Hsize) - ADDR_WIDTH'(1);

    // WRAP bursts stay inside a block of beats*bytes aligned to that block size.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] sz,
                                                        input logic [2:0] bu);
        logic [ADDR_WIDTH-1:0] inc, mask;
        inc  = ADDR_WIDTH'(1) << sz;
        mask = (inc << ({1'b0, bu[2:1]} + 3'd1)) - ADDR_WIDTH'(1);
        if (bu[2:1] != 2'b00 && !bu[0])
            return (a & ~mask) | ((a + inc) & mask);
        return a + inc;
    endfunction

`ifdef AHB_CHK_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pend_q, pend_d;

    // The counter parks at WAIT_LIM so the timeout fires only once per stall.
    always_comb begin
        pend_d      = Hreadyout ? accept : pend_q;
        wait_d      = wait_q;
        timeout_hit = 1'b0;
        if (Hreadyout) begin
            wait_d = '0;
        end else if (pend_q && wait_q != WAIT_LIM) begin
            wait_d      = wait_q + 1'b1;
            timeout_hit = wait_d == WAIT_LIM;
        end
    end

    always_ff @(posedge clock) begin
        if (Hreset) begin
            wait_q <= '0;
            pend_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            pend_q <= pend_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin : next_state
        state_d     = state_q;
        size_d      = size_q;
        burst_d     = burst_q;
        write_d     = write_q;
        exp_addr_d  = exp_addr_q;
        prev_addr_d = accept ? Haddr : prev_addr_q;
        beat_d      = beat_q;
        // A SEQ seen while idle is recovered as if it were a NONSEQ.
        open_evt    = accept && (is_nonseq || !in_burst);
        if (open_evt) begin
            size_d     = Hsize;
            burst_d    = Hburst;
            write_d    = Hwrite;
            exp_addr_d = next_addr(Haddr, Hsize, Hburst);
            beat_d     = 5'd1;
            state_d    = (Hburst != 3'b000) ? ST_BURST : ST_IDLE;
        end else if (accept) begin
            exp_addr_d = next_addr(Haddr, size_q, burst_q);
            if (beat_q != 5'd31)
                beat_d = beat_q + 5'd1;
            if (fixed_q && beat_d == (5'd2 << burst_q[2:1]))
                state_d = ST_IDLE;
        end else if (Hreadyout && is_idle) begin
            state_d = ST_IDLE;
        end
        abort_d = (state_d == ST_BURST) && !open_evt && (abort_q || resp_err);
    end

    always_comb begin : checks
        hit = '0;
        if (Hreadyout) begin
            hit[1] = is_seq && !in_burst;
            hit[2] = is_seq && in_burst && Haddr != exp_addr_q;
            hit[3] = (is_seq || is_busy) && in_burst &&
                     ({Hsize, Hburst, Hwrite} != {size_q, burst_q, write_q});
            hit[4] = (is_nonseq || is_idle) && in_burst && fixed_q && !(abort_q || resp_err);
            hit[5] = accept && ((32'd8 << Hsize) > 32'(DATA_WIDTH));
            hit[6] = accept && ((Haddr & size_mask) != '0);
            hit[8] = is_seq && in_burst && burst_q[0] &&
                     (Haddr[ADDR_WIDTH-1:10] != prev_addr_q[ADDR_WIDTH-1:10]);
        end
        hit[7] = timeout_hit;
        code_sel = 4'd0;
        for (int i = 8; i >= 1; i--)
            if (hit[i]) code_sel = 4'(i);
        err_valid_d = |hit;
        err_code_d  = err_valid_d ? code_sel : err_code_q;
        err_addr_d  = !err_valid_d ? err_addr_q : (code_sel == 4'd7) ? prev_addr_q : Haddr;
        err_cnt_d   = (err_valid_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        txn_d       = (accept && is_nonseq && txn_q != 16'hFFFF) ? txn_q + 16'd1 : txn_q;
    end

    always_ff @(posedge clock) begin : state_reg
        if (Hreset) begin
            state_q     <= ST_IDLE;
            size_q      <= '0;
            burst_q     <= '0;
            write_q     <= 1'b0;
            abort_q     <= 1'b0;
            exp_addr_q  <= '0;
            prev_addr_q <= '0;
            beat_q      <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
            txn_q       <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            write_q     <= write_d;
            abort_q     <= abort_d;
            exp_addr_q  <= exp_addr_d;
            prev_addr_q <= prev_addr_d;
            beat_q      <= beat_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            txn_q       <= txn_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin : outputs
        burst_active = state_q == ST_BURST;
        beat_count   = beat_q;
        err_valid    = err_valid_q;
        err_code     = err_code_q;
        err_addr     = err_addr_q;
        txn_count    = txn_q;
        err_count    = err_cnt_q;
    end
endmodule
